// File: rtl/register_bank.sv
// Addressed general-purpose register bank: one write port with eight ops (incl. two-step swap), two async read ports, carry flag.
// Latency: a write is visible on OUT_A/OUT_B right after the accepting strobe edge; swap completes on the following strobe edge.
// Backpressure: none queued; while BUSY=1 the incoming WR_OP is dropped, and edges without SLOW_CLOCK_STRB hold all state.
module register_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             ACLR_L,
    input  logic             SLOW_CLOCK_STRB,
    input  logic [2:0]       WR_OP,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    RD_ADDR_A,
    input  logic [AW-1:0]    RD_ADDR_B,
    output logic [WIDTH-1:0] OUT_A,
    output logic [WIDTH-1:0] OUT_B,
    output logic             ZERO_A,
    output logic             CARRY,
    output logic             BUSY
);

    localparam int HW = WIDTH / 2;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_MOV    = 3'b010;
    localparam logic [2:0] OP_LOADHI = 3'b011;
    localparam logic [2:0] OP_INC    = 3'b100;
    localparam logic [2:0] OP_DEC    = 3'b101;
    localparam logic [2:0] OP_CLR    = 3'b110;
    localparam logic [2:0] OP_SWAP   = 3'b111;

    typedef enum logic {IDLE, SWAP2} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] tmp;
    logic [AW-1:0]    swap_b;
    logic             carry_q, carry_nxt;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   inc_sum;
    logic             swap_start;

    // Decode the operation into a single array write plus next carry/state; only strobe edges do anything.
    always_comb begin
        state_nxt  = state;
        carry_nxt  = carry_q;
        wr_en      = 1'b0;
        wr_idx     = WR_ADDR;
        cur        = regs[WR_ADDR];
        wr_val     = cur;
        inc_sum    = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
        swap_start = 1'b0;
        if (SLOW_CLOCK_STRB) begin
            case (state)
                IDLE: begin
                    case (WR_OP)
                        OP_NOP: ;
                        OP_LOAD: begin
                            wr_en     = 1'b1;
                            wr_val    = IN;
                            carry_nxt = 1'b0;
                        end
                        OP_MOV: begin
                            wr_en     = 1'b1;
                            wr_val    = {{(WIDTH-HW){1'b0}}, IN[HW-1:0]};
                            carry_nxt = 1'b0;
                        end
                        OP_LOADHI: begin
                            wr_en     = 1'b1;
                            wr_val    = {IN[HW-1:0], cur[HW-1:0]};
                            carry_nxt = 1'b0;
                        end
                        OP_INC: begin
                            wr_en     = 1'b1;
                            wr_val    = inc_sum[WIDTH-1:0];
                            carry_nxt = inc_sum[WIDTH];
                        end
                        OP_DEC: begin
                            wr_en     = 1'b1;
                            wr_val    = cur - {{(WIDTH-1){1'b0}}, 1'b1};
                            carry_nxt = (cur == '0);
                        end
                        OP_CLR: begin
                            wr_en     = 1'b1;
                            wr_val    = '0;
                            carry_nxt = 1'b0;
                        end
                        OP_SWAP: begin
                            // First half: partner value moves into the target; old target is parked in tmp.
                            wr_en      = 1'b1;
                            wr_val     = regs[RD_ADDR_B];
                            swap_start = 1'b1;
                            state_nxt  = SWAP2;
                        end
                        default: ;
                    endcase
                end
                SWAP2: begin
                    // Second half ignores the op/address inputs entirely.
                    wr_en     = 1'b1;
                    wr_idx    = swap_b;
                    wr_val    = tmp;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register; reset aborts any pending swap half.
    always_ff @(posedge CLK) begin
        if (!ACLR_L) state <= IDLE;
        else         state <= state_nxt;
    end

    // Register array update: at most one entry written per edge.
    always_ff @(posedge CLK) begin
        if (!ACLR_L) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= wr_val;
        end
    end

    // Swap scratch state captured on the first swap edge.
    always_ff @(posedge CLK) begin
        if (!ACLR_L) begin
            tmp    <= '0;
            swap_b <= '0;
        end else if (swap_start) begin
            tmp    <= cur;
            swap_b <= RD_ADDR_B;
        end
    end

    // Carry/borrow flag.
    always_ff @(posedge CLK) begin
        if (!ACLR_L) carry_q <= 1'b0;
        else         carry_q <= carry_nxt;
    end

    // Read ports are plain array lookups with no write bypass.
    always_comb begin
        OUT_A  = regs[RD_ADDR_A];
        OUT_B  = regs[RD_ADDR_B];
        ZERO_A = (regs[RD_ADDR_A] == '0);
        CARRY  = carry_q;
        BUSY   = (state == SWAP2);
    end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a 16x4 and an 8x8 instance, directed steps followed by random ops vs. an integer model.
// Each step applies one clock edge, then compares every output a little after the edge.
// Model state is kept as plain integers per unit (0 = 16x4, 1 = 8x8).
module tb_register_bank;

    logic        CLK;
    logic        rstn [2];
    logic        strbv [2];
    logic [2:0]  opv [2];
    logic [2:0]  wav [2];
    logic [2:0]  rav [2];
    logic [2:0]  rbv [2];
    logic [15:0] din [2];

    logic [15:0] oa0, ob0;
    logic [7:0]  oa1, ob1;
    logic        z0, z1, c0, c1, b0, b1;

    int nvec = 0;
    int nerr = 0;

    int mr [2][8];
    int mc [2];
    int mb [2];
    int mt [2];
    int msw [2];

    register_bank #(.WIDTH(16), .DEPTH(4)) u_dut16 (
        .CLK(CLK), .ACLR_L(rstn[0]), .SLOW_CLOCK_STRB(strbv[0]), .WR_OP(opv[0]),
        .WR_ADDR(wav[0][1:0]), .IN(din[0]), .RD_ADDR_A(rav[0][1:0]), .RD_ADDR_B(rbv[0][1:0]),
        .OUT_A(oa0), .OUT_B(ob0), .ZERO_A(z0), .CARRY(c0), .BUSY(b0)
    );

    register_bank #(.WIDTH(8), .DEPTH(8)) u_dut8 (
        .CLK(CLK), .ACLR_L(rstn[1]), .SLOW_CLOCK_STRB(strbv[1]), .WR_OP(opv[1]),
        .WR_ADDR(wav[1]), .IN(din[1][7:0]), .RD_ADDR_A(rav[1]), .RD_ADDR_B(rbv[1]),
        .OUT_A(oa1), .OUT_B(ob1), .ZERO_A(z1), .CARRY(c1), .BUSY(b1)
    );

    initial begin
        CLK = 1'b0;
        forever #20 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] get_a(input int u);
        return (u == 0) ? oa0 : {8'h00, oa1};
    endfunction

    function automatic logic [15:0] get_b(input int u);
        return (u == 0) ? ob0 : {8'h00, ob1};
    endfunction

    // Behavioural model of one clock edge, written from the operation table.
    task automatic model_edge(input int u, input bit rst, input bit strb, input int op,
                              input int wa, input int rb, input int d);
        int w, md, hmd, depth;
        w     = (u == 0) ? 16 : 8;
        depth = (u == 0) ? 4 : 8;
        md    = 1 << w;
        hmd   = 1 << (w / 2);
        if (!rst) begin
            for (int i = 0; i < 8; i++) mr[u][i] = 0;
            mc[u] = 0; mb[u] = 0; mt[u] = 0; msw[u] = 0;
        end else if (strb) begin
            wa = wa % depth;
            rb = rb % depth;
            if (mb[u] != 0) begin
                mr[u][msw[u]] = mt[u];
                mb[u] = 0;
            end else begin
                case (op)
                    1: begin mr[u][wa] = d % md; mc[u] = 0; end
                    2: begin mr[u][wa] = d % hmd; mc[u] = 0; end
                    3: begin mr[u][wa] = (d % hmd) * hmd + mr[u][wa] % hmd; mc[u] = 0; end
                    4: begin mc[u] = (mr[u][wa] == md - 1) ? 1 : 0; mr[u][wa] = (mr[u][wa] + 1) % md; end
                    5: begin mc[u] = (mr[u][wa] == 0) ? 1 : 0; mr[u][wa] = (mr[u][wa] + md - 1) % md; end
                    6: begin mr[u][wa] = 0; mc[u] = 0; end
                    7: begin
                        mt[u] = mr[u][wa];
                        mr[u][wa] = mr[u][rb];
                        msw[u] = rb;
                        mb[u] = 1;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_outs(input int u);
        int depth;
        depth = (u == 0) ? 4 : 8;
        chk("out_a", get_a(u), 16'(mr[u][int'(rav[u]) % depth]));
        chk("out_b", get_b(u), 16'(mr[u][int'(rbv[u]) % depth]));
        chk("zero_a", 16'((u == 0) ? z0 : z1), 16'((mr[u][int'(rav[u]) % depth] == 0) ? 1 : 0));
        chk("carry", 16'((u == 0) ? c0 : c1), 16'(mc[u]));
        chk("busy", 16'((u == 0) ? b0 : b1), 16'(mb[u]));
    endtask

    // Sweep both read ports over every register (no clock edge involved).
    task automatic check_all(input int u);
        int depth;
        depth = (u == 0) ? 4 : 8;
        for (int a = 0; a < depth; a++) begin
            rav[u] = 3'(a);
            rbv[u] = 3'((a + 1) % depth);
            #1;
            chk("arr_a", get_a(u), 16'(mr[u][a]));
            chk("arr_b", get_b(u), 16'(mr[u][(a + 1) % depth]));
        end
    endtask

    task automatic step(input int u, input bit rst, input bit strb, input int op,
                        input int wa, input int ra, input int rb, input int d);
        rstn[u]    = rst;
        strbv[u]   = strb;
        opv[u]     = 3'(op);
        wav[u]     = 3'(wa);
        rav[u]     = 3'(ra);
        rbv[u]     = 3'(rb);
        din[u]     = 16'(d);
        rstn[1-u]  = 1'b1;
        strbv[1-u] = 1'b0;
        @(posedge CLK);
        model_edge(u, rst, strb, op, wa, rb, d);
        #1;
        check_outs(u);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rstn[u] = 1'b0; strbv[u] = 1'b0; opv[u] = '0; wav[u] = '0;
            rav[u] = '0; rbv[u] = '0; din[u] = '0;
        end

        // ---------------- 16x4 unit: directed ----------------
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_all(0);
        step(0, 1, 1, 1, 1, 1, 0, 16'hBEEF);
        chk("load_beef", oa0, 16'hBEEF);
        step(0, 1, 0, 1, 1, 1, 0, 16'h1234);
        chk("nostrb_hold", oa0, 16'hBEEF);
        step(0, 1, 1, 1, 2, 2, 0, 16'hFFFF);
        step(0, 1, 1, 4, 2, 2, 0, 0);
        chk("carry_set", 16'(c0), 16'h0001);
        step(0, 0, 0, 1, 1, 1, 0, 16'h5555);
        check_all(0);
        chk("rst_zero_a", 16'(z0), 16'h0001);
        chk("rst_carry", 16'(c0), 16'h0000);

        step(0, 1, 1, 1, 2, 2, 0, 16'hFFFF);
        step(0, 1, 1, 2, 2, 2, 0, 16'h12AB);
        chk("mov", oa0, 16'h00AB);
        step(0, 1, 1, 3, 2, 2, 0, 16'h0034);
        chk("loadhi", oa0, 16'h34AB);
        check_all(0);

        step(0, 1, 1, 1, 3, 3, 0, 16'hFFFF);
        step(0, 1, 1, 4, 3, 3, 0, 0);
        chk("inc_wrap", oa0, 16'h0000);
        chk("inc_carry", 16'(c0), 16'h0001);
        chk("inc_zero", 16'(z0), 16'h0001);
        step(0, 1, 1, 5, 3, 3, 0, 0);
        chk("dec_wrap", oa0, 16'hFFFF);
        chk("dec_borrow", 16'(c0), 16'h0001);
        step(0, 1, 1, 5, 3, 3, 0, 0);
        chk("dec_plain", oa0, 16'hFFFE);
        chk("dec_nocarry", 16'(c0), 16'h0000);

        step(0, 1, 1, 1, 0, 0, 1, 16'h1111);
        step(0, 1, 1, 1, 1, 0, 1, 16'h2222);
        step(0, 1, 1, 7, 0, 0, 1, 0);
        chk("swap1_r0", oa0, 16'h2222);
        chk("swap1_busy", 16'(b0), 16'h0001);
        step(0, 1, 0, 1, 3, 1, 2, 16'hDEAD);
        chk("swap_hold_busy", 16'(b0), 16'h0001);
        step(0, 1, 1, 1, 3, 1, 2, 16'hDEAD);
        chk("swap2_r1", oa0, 16'h1111);
        chk("swap2_busy", 16'(b0), 16'h0000);
        check_all(0);

        step(0, 1, 1, 7, 2, 2, 2, 0);
        chk("self_busy", 16'(b0), 16'h0001);
        step(0, 1, 1, 0, 2, 2, 2, 0);
        chk("self_val", oa0, 16'h34AB);
        chk("self_done", 16'(b0), 16'h0000);

        step(0, 1, 1, 7, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check_all(0);
        step(0, 1, 1, 1, 1, 1, 0, 16'h0777);
        chk("after_abort", oa0, 16'h0777);

        // ---------------- 8x8 unit: directed ----------------
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 0, 0, 7, 16'h005A);
        chk("w8_mov", {8'h00, oa1}, 16'h000A);
        step(1, 1, 1, 1, 7, 7, 0, 16'h00FF);
        step(1, 1, 1, 4, 7, 7, 0, 0);
        chk("w8_inc_wrap", {8'h00, oa1}, 16'h0000);
        chk("w8_inc_carry", 16'(c1), 16'h0001);
        step(1, 1, 1, 1, 7, 7, 0, 16'h00AA);
        check_all(1);

        // ---------------- random ops vs model ----------------
        for (int u = 0; u < 2; u++) begin
            int depth;
            depth = (u == 0) ? 4 : 8;
            for (int n = 0; n < 400; n++) begin
                bit rst, strb;
                rst  = ($urandom_range(0, 39) != 0);
                strb = ($urandom_range(0, 9) < 7);
                step(u, rst, strb, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, depth - 1)), int'($urandom_range(0, depth - 1)),
                     int'($urandom_range(0, depth - 1)), int'($urandom_range(0, 16'hFFFF)));
                if (n % 16 == 15) check_all(u);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
